// File: rtl/demux_1x4_reg.sv
// demux_1x4_reg: registered 1-to-4 dispatch demultiplexer with valid/ready handshakes.
// One producer word is steered by `control` into one of four single-entry slots.
// Each slot drains independently to its own consumer.
// in_ready depends only on `control` and the selected slot's state, so a stalled
// slot blocks only the words aimed at it.
// Optional build macro DEMUX_STATS_EN adds the clear_stats input and the
// xfer_count output: four saturating 8-bit per-slot acceptance counters.
// Data width comes from `INSTRUCTION_WIDTH (default 32).

`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif

module demux_1x4_reg #(
  parameter int WIDTH = `INSTRUCTION_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       control,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4
`ifdef DEMUX_STATS_EN
  ,
  input  logic             clear_stats,
  output logic [31:0]      xfer_count
`endif
);

  logic [3:0]       valid_q;
  logic [3:0]       valid_d;
  logic [WIDTH-1:0] data_q [4];
  logic [3:0]       wr_en_s;
  logic             sel_valid_s;
  logic             sel_ready_s;
  logic             accept_s;

  // Look up the state and the consumer-ready of the slot addressed by control.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_ready_s = 1'b0;
    case (control)
      2'd0: begin
        sel_valid_s = valid_q[0];
        sel_ready_s = out_ready[0];
      end
      2'd1: begin
        sel_valid_s = valid_q[1];
        sel_ready_s = out_ready[1];
      end
      2'd2: begin
        sel_valid_s = valid_q[2];
        sel_ready_s = out_ready[2];
      end
      2'd3: begin
        sel_valid_s = valid_q[3];
        sel_ready_s = out_ready[3];
      end
      default: begin
        sel_valid_s = 1'b0;
        sel_ready_s = 1'b0;
      end
    endcase
  end

  // The selected slot can take a word if it is empty or is being drained this cycle.
  assign in_ready = !sel_valid_s || sel_ready_s;
  assign accept_s = in_valid && in_ready;

  // Decode the accepted word into a one-hot slot write enable.
  always_comb begin
    wr_en_s = 4'b0000;
    if (accept_s) begin
      wr_en_s[control] = 1'b1;
    end else begin
      wr_en_s = 4'b0000;
    end
  end

  // Slot next state: a fill wins over a drain, so a simultaneous drain and fill keeps the slot FULL.
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < 4; i++) begin
      if (wr_en_s[i]) begin
        valid_d[i] = 1'b1;
      end else if (out_ready[i]) begin
        valid_d[i] = 1'b0;
      end else begin
        valid_d[i] = valid_q[i];
      end
    end
  end

  // Slot valid flags; reset empties all slots immediately, dropping any in-flight word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 4'b0000;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Slot data registers load only on a write, so a drained slot keeps its last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wr_en_s[i]) begin
          data_q[i] <= in_data;
        end else begin
          data_q[i] <= data_q[i];
        end
      end
    end
  end

  assign out_valid = valid_q;
  assign out1      = data_q[0];
  assign out2      = data_q[1];
  assign out3      = data_q[2];
  assign out4      = data_q[3];

`ifdef DEMUX_STATS_EN
  logic [7:0] cnt_q [4];

  // Per-slot acceptance counters; saturate at 255, and a clear wins over a same-cycle acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= 8'd0;
      end
    end else if (clear_stats) begin
      for (int i = 0; i < 4; i++) begin
        cnt_q[i] <= 8'd0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (wr_en_s[i] && (cnt_q[i] != 8'hFF)) begin
          cnt_q[i] <= cnt_q[i] + 8'd1;
        end else begin
          cnt_q[i] <= cnt_q[i];
        end
      end
    end
  end

  assign xfer_count = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule

// File: tb/tb_demux_1x4_reg.sv
// tb_demux_1x4_reg: directed self-checking bench for demux_1x4_reg.
// Inputs are driven 1 ns after the rising edge.
// Outputs are checked in the same settled window, away from the edges.

`timescale 1ns/1ps

module tb_demux_1x4_reg;

  logic        clk;
  logic        rst_n;
  logic [1:0]  control;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out1;
  logic [31:0] out2;
  logic [31:0] out3;
  logic [31:0] out4;
`ifdef DEMUX_STATS_EN
  logic        clear_stats;
  logic [31:0] xfer_count;
`endif

  int n_checks;
  int n_errors;

  demux_1x4_reg #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .control   (control),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out4      (out4)
`ifdef DEMUX_STATS_EN
    ,
    .clear_stats (clear_stats),
    .xfer_count  (xfer_count)
`endif
  );

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    control   = 2'd0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 4'b0000;
`ifdef DEMUX_STATS_EN
    clear_stats = 1'b0;
`endif

    // Reset state.
    #12;
    check_eq("rst_out_valid", {28'h0, out_valid}, 32'h0000_0000);
    check_eq("rst_out1", out1, 32'h0);
    check_eq("rst_out4", out4, 32'h0);
    check_eq("rst_in_ready", {31'h0, in_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Basic routing: control=10 sends the word to out3.
    control  = 2'd2;
    in_data  = 32'hDEAD_BEEF;
    in_valid = 1'b1;
    #1;
    check_eq("route_in_ready", {31'h0, in_ready}, 32'h1);
    check_eq("route_latency", {28'h0, out_valid}, 32'h0);
    step();
    in_valid = 1'b0;
    check_eq("route_out_valid", {28'h0, out_valid}, 32'h4);
    check_eq("route_out3", out3, 32'hDEAD_BEEF);
    check_eq("route_out1", out1, 32'h0);
    check_eq("route_out2", out2, 32'h0);
    check_eq("route_out4", out4, 32'h0);

    // Backpressure: fill slot 1, then a second word for slot 1 must stall.
    control  = 2'd0;
    in_data  = 32'h0000_00A1;
    in_valid = 1'b1;
    step();
    check_eq("bp_fill1_valid", {28'h0, out_valid}, 32'h5);
    in_data = 32'h0000_00B2;
    #1;
    check_eq("bp_in_ready_stall", {31'h0, in_ready}, 32'h0);
    step();
    check_eq("bp_out1_hold", out1, 32'h0000_00A1);
    check_eq("bp_valid_hold", {28'h0, out_valid}, 32'h5);
    control = 2'd1;
    #1;
    check_eq("bp_in_ready_other", {31'h0, in_ready}, 32'h1);
    step();
    in_valid = 1'b0;
    check_eq("bp_out2", out2, 32'h0000_00B2);
    check_eq("bp_valid_after", {28'h0, out_valid}, 32'h7);
    check_eq("bp_out1_still", out1, 32'h0000_00A1);

    // Simultaneous drain/fill of slot 4.
    control  = 2'd3;
    in_data  = 32'h0000_0011;
    in_valid = 1'b1;
    step();
    check_eq("df_fill4", out4, 32'h0000_0011);
    check_eq("df_all_full", {28'h0, out_valid}, 32'hF);
    out_ready = 4'b1000;
    in_data   = 32'h0000_0022;
    #1;
    check_eq("df_in_ready", {31'h0, in_ready}, 32'h1);
    step();
    check_eq("df_out4", out4, 32'h0000_0022);
    check_eq("df_valid", {28'h0, out_valid}, 32'hF);
    for (int k = 0; k < 8; k++) begin
      in_data = 32'h0000_0030 + k;
      #1;
      check_eq("df_stream_ready", {31'h0, in_ready}, 32'h1);
      step();
      check_eq("df_stream_out4", out4, 32'h0000_0030 + k);
      check_eq("df_stream_valid", {28'h0, out_valid}, 32'hF);
    end
    in_valid = 1'b0;
    step();
    check_eq("df_drain_valid", {28'h0, out_valid}, 32'h7);
    check_eq("df_drain_keep", out4, 32'h0000_0037);

    // Independent drains: refill slot 4, then drain slots 2 and 4 together.
    out_ready = 4'b0000;
    control   = 2'd3;
    in_data   = 32'h0000_0044;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    check_eq("ind_full", {28'h0, out_valid}, 32'hF);
    out_ready = 4'b1010;
    step();
    check_eq("ind_valid", {28'h0, out_valid}, 32'h5);
    check_eq("ind_out2_keep", out2, 32'h0000_00B2);
    check_eq("ind_out4_keep", out4, 32'h0000_0044);
    step();
    check_eq("ind_ready_on_empty", {28'h0, out_valid}, 32'h5);

    // Reset mid-cycle with slot 2 FULL.
    out_ready = 4'b0000;
    control   = 2'd1;
    in_data   = 32'h0000_0055;
    in_valid  = 1'b1;
    step();
    check_eq("mrst_pre_valid", {28'h0, out_valid}, 32'h7);
    check_eq("mrst_pre_out2", out2, 32'h0000_0055);
    in_data = 32'h0000_0066;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mrst_valid", {28'h0, out_valid}, 32'h0);
    check_eq("mrst_out2", out2, 32'h0);
    check_eq("mrst_out1", out1, 32'h0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("mrst_in_ready", {31'h0, in_ready}, 32'h1);
    step();
    check_eq("mrst_discard", {28'h0, out_valid}, 32'h0);

`ifdef DEMUX_STATS_EN
    // Saturating counter: 300 words to out1.
    out_ready = 4'b1111;
    control   = 2'd0;
    in_valid  = 1'b1;
    for (int k = 0; k < 300; k++) begin
      in_data = k;
      step();
    end
    in_valid = 1'b0;
    check_eq("stats_sat", xfer_count, 32'h0000_00FF);
    clear_stats = 1'b1;
    control     = 2'd2;
    in_valid    = 1'b1;
    step();
    clear_stats = 1'b0;
    in_valid    = 1'b0;
    check_eq("stats_clear", xfer_count, 32'h0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_eq("stats_one", xfer_count, 32'h0001_0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
